iterative_multdiv_execute: RTL and testbench

Execute-stage multi-cycle multiply/divide unit. It consumes the operand and control fields that the decode/execute pipeline register presents on the E side, and owns the hi and lo registers. It runs unsigned shift-add multiply or restoring division over WIDTH cycles. While busy it drives a stall back to the fetch/decode and decode/execute pipeline registers, so the front end holds until hi/lo are written.

---
 rtl/iterative_multdiv_execute_pkg.sv | 17 +
 rtl/iterative_multdiv_execute_datapath_step.sv | 41 ++++
 rtl/iterative_multdiv_execute.sv | 126 ++++++++++++
 tb/tb_iterative_multdiv_execute.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/iterative_multdiv_execute_pkg.sv
// Shared types and constants for the iterative multiply/divide execute unit.
// Imported by the top module and the single-iteration datapath step.
package iterative_multdiv_execute_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Quotient reported on divide by zero; sliced to WIDTH by the user
    localparam logic [63:0] DIVZERO_QUOT = '1;

endpackage

// File: rtl/iterative_multdiv_execute_datapath_step.sv
// One combinational iteration of unsigned shift-add multiply or
// restoring division over a 2*WIDTH-bit accumulator.
module multdiv_datapath_step
    import iterative_multdiv_execute_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               op_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, b_i};
        // Partial remainder after the left shift keeps its carried-out MSB
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        ge     = rem_sh >= {1'b0, b_i};
        diff   = rem_sh[WIDTH-1:0] - b_i;
        acc_o  = acc_i;
        if (op_i == OP_MUL) begin
            if (acc_i[0]) begin
                acc_o = {sum, acc_i[WIDTH-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
            end
        end else begin
            if (ge) begin
                acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/iterative_multdiv_execute.sv
// Execute-stage iterative multiply/divide unit owning hi/lo; stalls the
// front end for the duration of an operation.
module iterative_multdiv_execute
    import iterative_multdiv_execute_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Ehilowrite,
    input  logic             Emultdiv,
    input  logic [WIDTH-1:0] Erd1,
    input  logic [WIDTH-1:0] Erd2,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             divzero
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] step;

    multdiv_datapath_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op_i (op_q),
        .acc_i(acc_q),
        .b_i  (b_q),
        .acc_o(step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (Ehilowrite) begin
                    op_d = Emultdiv;
                    dz_d = 1'b0;
                    if (Emultdiv == OP_DIV && Erd2 == '0) begin
                        hi_d    = Erd1;
                        lo_d    = DIVZERO_QUOT[WIDTH-1:0];
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        // Multiply keeps the multiplier in the low half;
                        // divide keeps the dividend there.
                        if (Emultdiv == OP_MUL) begin
                            acc_d = {{WIDTH{1'b0}}, Erd2};
                            b_d   = Erd1;
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, Erd1};
                            b_d   = Erd2;
                        end
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    hi_d    = step[2*WIDTH-1:WIDTH];
                    lo_d    = step[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            op_q    <= OP_MUL;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign done    = done_q;
    assign divzero = dz_q;
    assign busy    = (state_q == RUN);
    assign stall   = (state_q == RUN) ||
                     ((state_q == IDLE || state_q == DONE) && Ehilowrite);

endmodule

// File: tb/tb_iterative_multdiv_execute.sv
// Scoreboard bench for iterative_multdiv_execute: expected hi/lo/divzero
// and done cycle are queued at start and checked on each done pulse.
module tb_iterative_multdiv_execute;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         Ehilowrite;
    logic         Emultdiv;
    logic [W-1:0] Erd1;
    logic [W-1:0] Erd2;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         stall;
    logic         done;
    logic         divzero;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    iterative_multdiv_execute #(
        .WIDTH(W),
        .CNT_W(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Ehilowrite(Ehilowrite),
        .Emultdiv  (Emultdiv),
        .Erd1      (Erd1),
        .Erd2      (Erd2),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .divzero   (divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", 32'(hi), 32'(e.hi));
                chk("lo", 32'(lo), 32'(e.lo));
                chk("divzero", 32'(divzero), 32'(e.dz));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the DONE cycle
    // (or two cycles after an aborting reset).
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic m, input bit noisy, input int abort_at);
        exp_t         e;
        logic [31:0]  p;
        logic [W-1:0] hh, ll;
        bit           dz;
        int           t;
        dz         = (m == 1'b1) && (b == '0);
        Ehilowrite = 1'b1;
        Emultdiv   = m;
        Erd1       = a;
        Erd2       = b;
        t          = cyc;
        if (dz) begin
            e.hi = a;
            e.lo = '1;
        end else if (m) begin
            e.hi = a % b;
            e.lo = a / b;
        end else begin
            p    = {16'd0, a} * {16'd0, b};
            e.hi = p[31:16];
            e.lo = p[15:0];
        end
        e.dz  = dz;
        e.cyc = t + (dz ? 1 : W + 1);
        if (abort_at == 0) sb.push_back(e);
        @(negedge clk);
        chk("stall_start", 32'(stall), 32'd1);
        hh = hi;
        ll = lo;
        if (!dz) begin
            for (int i = 1; i <= W; i++) begin
                @(posedge clk);
                #1;
                if (noisy) begin
                    Ehilowrite = 1'($urandom);
                    Emultdiv   = 1'($urandom);
                    Erd1       = W'($urandom);
                    Erd2       = W'($urandom);
                end else begin
                    Ehilowrite = 1'b0;
                end
                if (i == abort_at) reset = 1'b1;
                @(negedge clk);
                chk("stall_run", 32'(stall), 32'd1);
                chk("busy_run", 32'(busy), 32'd1);
                chk("hi_hold", 32'(hi), 32'(hh));
                chk("lo_hold", 32'(lo), 32'(ll));
                if (i == 1) chk("divzero_clr", 32'(divzero), 32'd0);
                if (i == abort_at) break;
            end
            if (abort_at != 0) begin
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                chk("abort_hi", 32'(hi), 32'd0);
                chk("abort_lo", 32'(lo), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_stall", 32'(stall), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        Ehilowrite = 1'b0;
        Emultdiv   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset      = 1'b1;
        Ehilowrite = 1'b0;
        Emultdiv   = 1'b0;
        Erd1       = '0;
        Erd2       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", 32'(hi), 32'd0);
        chk("rst_lo", 32'(lo), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_divzero", 32'(divzero), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        op(16'h1234, 16'h5678, 1'b0, 1'b0, 0);
        idle(1);
        op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0);
        op(16'h0003, 16'h0005, 1'b0, 1'b0, 0);
        idle(1);
        op(16'd100, 16'd7, 1'b1, 1'b0, 0);
        idle(1);
        op(16'hFFFF, 16'h0010, 1'b1, 1'b0, 0);
        idle(1);
        op(16'h1234, 16'h0000, 1'b1, 1'b0, 0);
        idle(1);
        op(16'h0055, 16'h0003, 1'b1, 1'b0, 0);
        idle(1);
        op(16'h0ABC, 16'h0DEF, 1'b0, 1'b0, 8);
        idle(1);
        op(16'h0ABC, 16'h0DEF, 1'b0, 1'b0, 0);
        idle(1);
        op(16'h8000, 16'hFFFF, 1'b1, 1'b0, 0);
        idle(1);
        for (int k = 0; k < 8; k++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (k == 5) ? '0 : W'($urandom_range(0, 16'hFFFF));
            op(ra, rb, 1'((k + 1) % 2), 1'b1, 0);
        end
        idle(1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
